// File: rtl/cordic_atan2.sv
// cordic_atan2: iterative CORDIC vectoring engine returning atan2(y, x) and magnitude.
// Define CORDIC_ATAN2_GAIN_COMP_EN to add the SCALE state that removes the CORDIC gain from the magnitude.
module cordic_atan2 #(
  parameter int ITERATIONS = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] angle_radian,
  output logic [15:0] magnitude
);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ITER, S_SCALE, S_OUT} state_t;
  localparam logic signed [17:0] Z_PI = 18'sd51472;
  localparam logic [3:0] LAST = 4'(ITERATIONS - 1);
  localparam logic signed [17:0] ATAN [14] = '{
    18'sd12868, 18'sd7596, 18'sd4014, 18'sd2037, 18'sd1023, 18'sd512, 18'sd256,
    18'sd128, 18'sd64, 18'sd32, 18'sd16, 18'sd8, 18'sd4, 18'sd2
  };
  state_t             r_state;
  logic signed [19:0] r_x, r_y, w_xs, w_ys, w_src;
  logic signed [17:0] r_z, w_z_rnd;
  logic [3:0]         r_i;
  logic               r_zero;
  logic [15:0]        w_mag_sat;
  assign w_xs      = r_x >>> r_i;
  assign w_ys      = r_y >>> r_i;
  assign w_z_rnd   = r_z + 18'sd1;
  assign w_mag_sat = w_src[19] ? 16'd0 : (|w_src[18:16]) ? 16'hffff : w_src[15:0];
`ifdef CORDIC_ATAN2_GAIN_COMP_EN
  logic signed [19:0] r_mag;
  logic signed [35:0] w_prod;
  assign w_prod = $signed({{16{r_x[19]}}, r_x}) * 36'sd9949;
  assign w_src  = r_mag;
`else
  assign w_src  = r_x;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_z          <= '0;
      r_i          <= '0;
      r_zero       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      angle_radian <= '0;
      magnitude    <= '0;
`ifdef CORDIC_ATAN2_GAIN_COMP_EN
      r_mag        <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_x     <= {{4{x_in[15]}}, x_in};
          r_y     <= {{4{y_in[15]}}, y_in};
          r_zero  <= ~|{x_in, y_in};
          busy    <= 1'b1;
          r_state <= S_PRE;
        end
        // Left half-plane is folded by 180 degrees so the iterations only ever see x >= 0
        S_PRE: begin
          r_x     <= r_x[19] ? -r_x : r_x;
          r_y     <= r_x[19] ? -r_y : r_y;
          r_z     <= !r_x[19] ? 18'sd0 : r_y[19] ? -Z_PI : Z_PI;
          r_i     <= '0;
          r_state <= S_ITER;
        end
        S_ITER: begin
          r_x     <= r_y[19] ? r_x - w_ys : r_x + w_ys;
          r_y     <= r_y[19] ? r_y + w_xs : r_y - w_xs;
          r_z     <= r_y[19] ? r_z - ATAN[r_i] : r_z + ATAN[r_i];
          r_i     <= r_i + 4'd1;
`ifdef CORDIC_ATAN2_GAIN_COMP_EN
          r_state <= (r_i == LAST) ? S_SCALE : S_ITER;
`else
          r_state <= (r_i == LAST) ? S_OUT : S_ITER;
`endif
        end
`ifdef CORDIC_ATAN2_GAIN_COMP_EN
        S_SCALE: begin
          r_mag   <= 20'(w_prod >>> 14);
          r_state <= S_OUT;
        end
`endif
        S_OUT: begin
          angle_radian <= r_zero ? 16'd0 : 16'(w_z_rnd >>> 1);
          magnitude    <= r_zero ? 16'd0 : w_mag_sat;
          done         <= 1'b1;
          busy         <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_atan2.sv
// tb_cordic_atan2: directed vectors for cordic_atan2 with a queue scoreboard checked on every done pulse.
module tb_cordic_atan2;
`ifdef CORDIC_ATAN2_GAIN_COMP_EN
  localparam int  LAT  = 17;
  localparam int  MTOL = 6;
  localparam bit  GC   = 1'b1;
`else
  localparam int  LAT  = 16;
  localparam int  MTOL = 20;
  localparam bit  GC   = 1'b0;
`endif
  localparam int ATOL = 3;
  typedef struct {int a; int m; string nm;} exp_t;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [15:0] x_in = '0, y_in = '0;
  logic        busy, done;
  logic [15:0] angle_radian, magnitude;
  exp_t        sb[$];
  int          n_tests = 0, n_fail = 0, cyc = 0;
  cordic_atan2 #(.ITERATIONS(14)) dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .busy(busy), .done(done), .angle_radian(angle_radian), .magnitude(magnitude)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp, input int tol);
    n_tests++;
    if (act - exp > tol || exp - act > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask
  task automatic push(input int a, input int m_true, input int m_raw, input string nm);
    exp_t e;
    e.a = a; e.m = GC ? m_true : m_raw; e.nm = nm;
    sb.push_back(e);
  endtask
  task automatic wait_done(output int c);
    c = -1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done) begin c = cyc; return; end
    end
  endtask
  task automatic run(input int x, input int y, input int a, input int m_true, input int m_raw,
                     input string nm, input int glitch);
    int lat; bit bad;
    @(negedge clk);
    x_in = 16'(x); y_in = 16'(y); start = 1'b1;
    push(a, m_true, m_raw, nm);
    @(posedge clk); #1;
    start = 1'b0; lat = -1; bad = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == glitch) begin start = 1'b1; x_in = 16'hc000; y_in = 16'h0000; end
      if (k == glitch + 1) start = 1'b0;
      if (done) begin lat = k; break; end
      if (!busy) bad = 1'b1;
    end
    chk({nm, "_latency"}, lat, LAT, 0);
    chk({nm, "_busy_during"}, int'(bad), 0, 0);
    chk({nm, "_busy_at_done"}, int'(busy), 0, 0);
    if (glitch > 0) begin
      bad = 1'b0;
      repeat (3) begin @(posedge clk); #1; if (busy || done) bad = 1'b1; end
      chk({nm, "_midop_start_ignored"}, int'(bad), 0, 0);
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no result pending");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.nm, "_angle"}, int'($signed(angle_radian)), e.a, ATOL);
          chk({e.nm, "_mag"}, int'(magnitude), e.m, MTOL);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within bound");
    $fatal(1, "timeout");
  end
  initial begin
    int c0, c1, c2, c3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_done", int'(done), 0, 0);
    chk("rst_angle", int'(angle_radian), 0, 0);
    chk("rst_mag", int'(magnitude), 0, 0);
    @(negedge clk); reset = 1'b1;
    run(16384, 0, 0, 16384, 26981, "x_axis", 0);
    run(11585, 11585, 6434, 16384, 26980, "diag45", 5);
    run(-16384, 0, 25736, 16384, 26981, "neg_x", 0);
    run(0, -16384, -12868, 16384, 26981, "neg_y", 0);
    run(-32768, -32768, -19302, 46341, 65535, "diag_m135", 0);
    // abort mid-operation: outputs held from the previous result must clear at once
    @(negedge clk);
    x_in = 16'h4000; y_in = 16'h4000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (6) @(posedge clk);
    #1; reset = 1'b0; #1;
    chk("abort_busy", int'(busy), 0, 0);
    chk("abort_done", int'(done), 0, 0);
    chk("abort_angle", int'(angle_radian), 0, 0);
    chk("abort_mag", int'(magnitude), 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    run(16384, 0, 0, 16384, 26981, "after_reset", 0);
    run(0, 0, 0, 0, 0, "zero_vec", 0);
    // start held high: second operation accepted on the first IDLE edge after done
    @(negedge clk);
    x_in = 16'h4000; y_in = 16'h0000; start = 1'b1;
    push(0, 16384, 26981, "hold1");
    push(0, 16384, 26981, "hold2");
    @(posedge clk); #1; c0 = cyc;
    wait_done(c1);
    chk("hold_first_latency", c1 - c0, LAT, 0);
    @(posedge clk); #1; start = 1'b0; c2 = cyc;
    chk("hold_reaccept_busy", int'(busy), 1, 0);
    wait_done(c3);
    chk("hold_throughput", c3 - c1, LAT + 1, 0);
    chk("hold_second_latency", c3 - c2, LAT, 0);
    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
